// File: rtl/gpio_bus_arbiter.sv
// Two-requester arbiter onto a single-outstanding AXI4-Lite master port.
// Define GPIO_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round robin.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_arst,
  input  logic [1:0]            r_req,
  input  logic [1:0]            r_we,
  input  logic [2*ADDR_W-1:0]   r_addr,
  input  logic [63:0]           r_wdata,
  output logic [1:0]            r_ack,
  output logic [31:0]           r_rdata,
  output logic                  M_AXI_AWVALID,
  output logic [31:0]           M_AXI_AWADDR,
  input  logic                  M_AXI_AWREADY,
  output logic                  M_AXI_WVALID,
  output logic [31:0]           M_AXI_WDATA,
  input  logic                  M_AXI_WREADY,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic                  M_AXI_ARVALID,
  output logic [31:0]           M_AXI_ARADDR,
  input  logic                  M_AXI_ARREADY,
  input  logic                  M_AXI_RVALID,
  input  logic [31:0]           M_AXI_RDATA,
  output logic                  M_AXI_RREADY
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] ACK     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              pick;
  logic              aw_hs, w_hs;

`ifdef GPIO_ARB_FIXED_PRIO_EN
  assign pick = ~r_req[0];
`else
  // last_q holds the index granted most recently; the other requester wins a tie.
  logic last_q, last_d;
  assign pick = (r_req == 2'b11) ? ~last_q : r_req[1];
`endif

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifndef GPIO_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|r_req) begin
          grant_d   = pick;
          addr_d    = pick ? r_addr[2*ADDR_W-1:ADDR_W] : r_addr[ADDR_W-1:0];
          wdata_d   = pick ? r_wdata[63:32] : r_wdata[31:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = r_we[pick] ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RESP;
      end
      WR_RESP: if (M_AXI_BVALID) state_d = ACK;
      RD_ADDR: if (M_AXI_ARREADY) state_d = RD_DATA;
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          state_d = ACK;
        end
      end
      ACK: begin
`ifndef GPIO_ARB_FIXED_PRIO_EN
        last_d  = grant_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (axi_arst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifndef GPIO_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign M_AXI_AWVALID = (state_q == WR) & ~aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR) & ~w_done_q;
  assign M_AXI_AWADDR  = {{(32-ADDR_W){1'b0}}, addr_q};
  assign M_AXI_ARADDR  = {{(32-ADDR_W){1'b0}}, addr_q};
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);
  assign r_ack         = (state_q == ACK) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign r_rdata       = rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: vector table of transactions against a simple AXI-Lite slave, plus a reset-abort sequence.
module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        axi_arst;
  logic [1:0]  r_req, r_we, r_ack;
  logic [15:0] r_addr;
  logic [63:0] r_wdata;
  logic [31:0] r_rdata;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.ADDR_W(8)) dut (
    .axi_aclk(clk), .axi_arst(axi_arst),
    .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_ack(r_ack), .r_rdata(r_rdata),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          aw_lat;
    int          w_lat;
    logic [31:0] slv_rdata;
    logic        drop_req;
    logic        exp_grant;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
  endtask

  // Drives one request and plays slave until r_ack, then checks the outcome.
  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0]  ea;
    logic [31:0] ew;
    logic        is_wr;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0, done = 0;
    ea    = v.exp_grant ? v.addr[15:8] : v.addr[7:0];
    ew    = v.exp_grant ? v.wdata[63:32] : v.wdata[31:0];
    is_wr = v.we[v.exp_grant];
    r_req = v.req; r_we = v.we; r_addr = v.addr; r_wdata = v.wdata;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (v.drop_req && cyc == 1) begin
        r_req = 2'b00; r_addr = 16'hFFFF; r_wdata = '1;
      end
      if (r_ack != 2'b00) begin
        check({tag, ".ack"}, r_ack, v.exp_grant ? 2'b10 : 2'b01);
        check({tag, ".rdata"}, r_rdata, v.exp_rdata);
        if (is_wr) begin
          check({tag, ".aw_hs"}, aw_hs, 1);
          check({tag, ".w_hs"}, w_hs, 1);
          check({tag, ".b_hs"}, b_hs, 1);
          check({tag, ".ar_hs"}, ar_hs, 0);
        end else begin
          check({tag, ".ar_hs"}, ar_hs, 1);
          check({tag, ".r_hs"}, r_hs, 1);
          check({tag, ".aw_hs"}, aw_hs, 0);
        end
        slave_idle();
        done = 1;
      end else begin
        if (aw_pend) check({tag, ".aw_held"}, M_AXI_AWVALID, 1'b1);
        if (w_pend)  check({tag, ".w_held"}, M_AXI_WVALID, 1'b1);
        if (ar_pend) check({tag, ".ar_held"}, M_AXI_ARVALID, 1'b1);
        M_AXI_AWREADY = 1'b0;
        if (M_AXI_AWVALID) begin
          if (aw_wait >= v.aw_lat) begin
            M_AXI_AWREADY = 1'b1; aw_hs++;
            check({tag, ".awaddr"}, M_AXI_AWADDR, {24'h0, ea});
          end else aw_wait++;
        end
        M_AXI_WREADY = 1'b0;
        if (M_AXI_WVALID) begin
          if (w_wait >= v.w_lat) begin
            M_AXI_WREADY = 1'b1; w_hs++;
            check({tag, ".wdata"}, M_AXI_WDATA, ew);
          end else w_wait++;
        end
        M_AXI_ARREADY = 1'b0;
        if (M_AXI_ARVALID) begin
          if (ar_wait >= v.aw_lat) begin
            M_AXI_ARREADY = 1'b1; ar_hs++;
            check({tag, ".araddr"}, M_AXI_ARADDR, {24'h0, ea});
          end else ar_wait++;
        end
        M_AXI_BVALID = M_AXI_BREADY;
        if (M_AXI_BREADY) begin
          b_hs++;
          check({tag, ".bready_after_aw_w"}, aw_hs + w_hs, 2);
        end
        M_AXI_RVALID = M_AXI_RREADY;
        M_AXI_RDATA  = M_AXI_RREADY ? v.slv_rdata : 32'h0;
        if (M_AXI_RREADY) r_hs++;
        aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
        w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
        ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
      end
    end
    check({tag, ".completed"}, done, 1'b1);
    @(negedge clk);
    check({tag, ".ack_one_cycle"}, r_ack, 2'b00);
    check({tag, ".rdata_hold"}, r_rdata, v.exp_rdata);
  endtask

  initial begin
    bit seen;
    //          req    we     addr      wdata                  awl wl slv_rdata     drop  grant exp_rdata
    vecs[0] = '{2'b01, 2'b01, 16'h0044, 64'h0000_0000_0000_0002, 1, 1, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[1] = '{2'b10, 2'b00, 16'h4800, 64'h0,                   0, 0, 32'hA5A5_0001, 1'b0, 1'b1, 32'hA5A5_0001};
    vecs[2] = '{2'b01, 2'b01, 16'h004C, 64'h0000_0000_0000_1234, 0, 3, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001};
    vecs[3] = '{2'b10, 2'b10, 16'h6000, 64'hCAFE_0000_0000_0000, 0, 0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
`ifdef GPIO_ARB_FIXED_PRIO_EN
    vecs[4] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h11,        1'b0, 1'b0, 32'h11};
    vecs[5] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h33,        1'b0, 1'b0, 32'h33};
    vecs[6] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h22,        1'b0, 1'b0, 32'h22};
    vecs[7] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h44,        1'b0, 1'b0, 32'h44};
    vecs[9] = '{2'b11, 2'b01, 16'h3038, 64'h0000_0000_0000_0099, 0, 0, 32'h55,        1'b0, 1'b0, 32'h0};
`else
    vecs[4] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h11,        1'b0, 1'b0, 32'h11};
    vecs[5] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h33,        1'b0, 1'b1, 32'h11};
    vecs[6] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h22,        1'b0, 1'b0, 32'h22};
    vecs[7] = '{2'b11, 2'b10, 16'h2010, 64'h0000_0077_0000_0000, 0, 0, 32'h44,        1'b0, 1'b1, 32'h22};
    vecs[9] = '{2'b11, 2'b01, 16'h3038, 64'h0000_0000_0000_0099, 0, 0, 32'h55,        1'b0, 1'b1, 32'h55};
`endif
    vecs[8] = '{2'b11, 2'b01, 16'h3038, 64'h0000_0000_0000_0099, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0};

    axi_arst = 1'b1; r_req = '0; r_we = '0; r_addr = '0; r_wdata = '0;
    slave_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ctrl", {r_ack, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 7'h0);
    check("reset.rdata", r_rdata, 32'h0);
    axi_arst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Abort a read while waiting for RVALID.
    r_req = 2'b01; r_we = 2'b00; r_addr = 16'h0050;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      M_AXI_ARREADY = M_AXI_ARVALID;
      if (M_AXI_RREADY) seen = 1;
    end
    check("abort.reached_rd_data", seen, 1'b1);
    M_AXI_ARREADY = 1'b0; axi_arst = 1'b1; r_req = 2'b00;
    @(negedge clk);
    check("abort.ctrl", {r_ack, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 7'h0);
    check("abort.rdata", r_rdata, 32'h0);
    check("abort.addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
    axi_arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort.no_ack", {r_ack, M_AXI_RREADY}, 3'b000);
    end

    run_txn(vecs[8], "v8");
    run_txn(vecs[9], "v9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
